quad_clock_divider: RTL and testbench

- Single-clock, fully synchronous quadrature divider: produces in-phase (I) and quadrature (Q) square waves at f_clk/(4*N).
- N is programmable at run time; a direction control selects whether Q lags or leads I.
- Sits between the system clock and mixer/sampler logic as the generalised successor of the fixed divide-by-4 ripple I/Q generator; no derived clocks, all outputs are registered.

---
 rtl/quad_clock_divider_if.sv | 35 +++
 rtl/quad_clock_divider.sv | 172 +++++++++++++++++
 tb/tb_quad_clock_divider.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/quad_clock_divider_if.sv
// Control and output bundle for quad_clock_divider.
// Optional phase_oh member exists only when QUAD_DIV_PHASE4_EN is defined.
interface quad_clock_divider_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic [DIV_W-1:0] div_in;
  logic             div_load;
  logic             q_lead;
  logic             out_i;
  logic             out_q;
  logic [1:0]       phase;
  logic             sync;
`ifdef QUAD_DIV_PHASE4_EN
  logic [3:0]       phase_oh;

  modport master (
    output en, div_in, div_load, q_lead,
    input  out_i, out_q, phase, sync, phase_oh
  );
  modport slave (
    input  en, div_in, div_load, q_lead,
    output out_i, out_q, phase, sync, phase_oh
  );
`else
  modport master (
    output en, div_in, div_load, q_lead,
    input  out_i, out_q, phase, sync
  );
  modport slave (
    input  en, div_in, div_load, q_lead,
    output out_i, out_q, phase, sync
  );
`endif
endinterface

// File: rtl/quad_clock_divider.sv
// Programmable I/Q quadrature divider: out_i/out_q at f_clk/(4*N), glitch-free ratio updates.
// Define QUAD_DIV_PHASE4_EN to add the registered four-phase one-hot output phase_oh.
module quad_clock_divider #(
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  quad_clock_divider_if.slave  bus
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A ratio of zero behaves as divide-by-one.
  function automatic logic [DIV_W-1:0] last_count(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : (d - ONE);
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic dir);
    return dir ? (ph - 2'd1) : (ph + 2'd1);
  endfunction

  function automatic logic [1:0] last_phase(input logic dir);
    return dir ? 2'd1 : 2'd3;
  endfunction

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [1:0]       phase, phase_nxt;
  logic [DIV_W-1:0] div_reg, div_nxt;
  logic [DIV_W-1:0] pend_div, pend_div_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic             dir_reg, dir_nxt;
  logic             sync_nxt;
  logic             running, running_nxt;
  logic             tick, boundary;

  logic             out_i_p1, out_q_p1, sync_p1;
  logic             out_i_p0, out_q_p0;
`ifdef QUAD_DIV_PHASE4_EN
  logic [3:0]       phase_oh_p0, phase_oh_p1;
`endif

  assign running  = (state == ST_RUN);
  assign tick     = running && (cnt == last_count(div_reg));
  assign boundary = tick && (phase == last_phase(dir_reg));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      phase      <= 2'd0;
      div_reg    <= RST_DIV;
      pend_div   <= '0;
      pend_valid <= 1'b0;
      dir_reg    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      phase      <= phase_nxt;
      div_reg    <= div_nxt;
      pend_div   <= pend_div_nxt;
      pend_valid <= pend_valid_nxt;
      dir_reg    <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    phase_nxt      = phase;
    div_nxt        = div_reg;
    pend_div_nxt   = pend_div;
    pend_valid_nxt = pend_valid;
    dir_nxt        = dir_reg;
    sync_nxt       = 1'b0;

    if (!bus.en) begin
      // Outputs are forced low while stopped, so a held pending ratio can be committed safely.
      state_nxt      = ST_IDLE;
      cnt_nxt        = '0;
      phase_nxt      = 2'd0;
      pend_valid_nxt = 1'b0;
      if (bus.div_load) begin
        div_nxt = bus.div_in;
      end else if (pend_valid) begin
        div_nxt = pend_div;
      end
    end else if (state == ST_IDLE) begin
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
      phase_nxt = 2'd0;
      dir_nxt   = bus.q_lead;
      sync_nxt  = 1'b1;
      if (bus.div_load) begin
        div_nxt = bus.div_in;
      end
    end else if (boundary) begin
      cnt_nxt        = '0;
      phase_nxt      = next_phase(phase, dir_reg);
      dir_nxt        = bus.q_lead;
      sync_nxt       = 1'b1;
      pend_valid_nxt = 1'b0;
      if (bus.div_load) begin
        div_nxt = bus.div_in;
      end else if (pend_valid) begin
        div_nxt = pend_div;
      end
    end else begin
      if (tick) begin
        cnt_nxt   = '0;
        phase_nxt = next_phase(phase, dir_reg);
      end else begin
        cnt_nxt = cnt + ONE;
      end
      if (bus.div_load) begin
        pend_div_nxt   = bus.div_in;
        pend_valid_nxt = 1'b1;
      end
    end
  end

  // Stage p0: decode outputs from next state so they align with the state they describe.
  assign running_nxt = (state_nxt == ST_RUN);
  assign out_i_p0    = running_nxt && !phase_nxt[1];
  assign out_q_p0    = running_nxt && (phase_nxt[1] ^ phase_nxt[0]);
`ifdef QUAD_DIV_PHASE4_EN
  always_comb begin
    phase_oh_p0 = 4'b0000;
    if (running_nxt) begin
      phase_oh_p0[phase_nxt] = 1'b1;
    end
  end
`endif

  // Stage p1: registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_i_p1 <= 1'b0;
      out_q_p1 <= 1'b0;
      sync_p1  <= 1'b0;
    end else begin
      out_i_p1 <= out_i_p0;
      out_q_p1 <= out_q_p0;
      sync_p1  <= sync_nxt;
    end
  end

`ifdef QUAD_DIV_PHASE4_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_oh_p1 <= 4'b0000;
    end else begin
      phase_oh_p1 <= phase_oh_p0;
    end
  end

  assign bus.phase_oh = phase_oh_p1;
`endif

  assign bus.out_i = out_i_p1;
  assign bus.out_q = out_q_p1;
  assign bus.sync  = sync_p1;
  assign bus.phase = phase;

endmodule

// File: tb/tb_quad_clock_divider.sv
// Self-checking bench for quad_clock_divider: vector table plus scoreboarded multi-cycle sequences.
module tb_quad_clock_divider;

  typedef struct packed {
    logic       i;
    logic       q;
    logic [1:0] ph;
    logic       s;
  } exp_t;

  typedef struct {
    logic       en;
    logic       ld;
    logic [7:0] din;
    logic       ql;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  vec_t vecs[12];

  localparam exp_t ZERO = '{i: 1'b0, q: 1'b0, ph: 2'd0, s: 1'b0};

  quad_clock_divider_if #(.DIV_W(8)) bus ();

  quad_clock_divider #(.DIV_W(8), .RESET_DIV(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Ideal waveform t cycles after the start of a period run at ratio n.
  function automatic exp_t wave(input int n, input bit dir, input int t);
    exp_t e;
    int   k;
    k    = (t / n) % 4;
    e.ph = dir ? 2'((4 - k) % 4) : 2'(k);
    e.i  = (e.ph == 2'd0) || (e.ph == 2'd1);
    e.q  = (e.ph == 2'd1) || (e.ph == 2'd2);
    e.s  = ((t % (4 * n)) == 0);
    return e;
  endfunction

  task automatic check_out(input string nm);
    exp_t e, act;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e   = sb.pop_front();
      act = '{i: bus.out_i, q: bus.out_q, ph: bus.phase, s: bus.sync};
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got i/q/ph/sync=%b/%b/%0d/%b required %b/%b/%0d/%b",
                 nm, act.i, act.q, act.ph, act.s, e.i, e.q, e.ph, e.s);
      end
    end
  endtask

  task automatic apply(input logic en_v, input logic ld_v, input logic [7:0] din_v,
                       input logic ql_v, input exp_t e, input string nm);
    bus.en       = en_v;
    bus.div_load = ld_v;
    bus.div_in   = din_v;
    bus.q_lead   = ql_v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(nm);
  endtask

  initial begin
    exp_t e;
    logic ql;

    vecs[0]  = '{1'b1, 1'b0, 8'd0, 1'b0, '{1'b1, 1'b0, 2'd0, 1'b1}};
    vecs[1]  = '{1'b1, 1'b0, 8'd0, 1'b0, '{1'b1, 1'b1, 2'd1, 1'b0}};
    vecs[2]  = '{1'b1, 1'b0, 8'd0, 1'b0, '{1'b0, 1'b1, 2'd2, 1'b0}};
    vecs[3]  = '{1'b1, 1'b0, 8'd0, 1'b0, '{1'b0, 1'b0, 2'd3, 1'b0}};
    vecs[4]  = '{1'b1, 1'b0, 8'd0, 1'b0, '{1'b1, 1'b0, 2'd0, 1'b1}};
    vecs[5]  = '{1'b1, 1'b0, 8'd0, 1'b0, '{1'b1, 1'b1, 2'd1, 1'b0}};
    vecs[6]  = '{1'b1, 1'b0, 8'd0, 1'b0, '{1'b0, 1'b1, 2'd2, 1'b0}};
    vecs[7]  = '{1'b1, 1'b0, 8'd0, 1'b0, '{1'b0, 1'b0, 2'd3, 1'b0}};
    vecs[8]  = '{1'b0, 1'b0, 8'd0, 1'b0, '{1'b0, 1'b0, 2'd0, 1'b0}};
    vecs[9]  = '{1'b0, 1'b1, 8'd3, 1'b0, '{1'b0, 1'b0, 2'd0, 1'b0}};
    vecs[10] = '{1'b1, 1'b0, 8'd0, 1'b0, '{1'b1, 1'b0, 2'd0, 1'b1}};
    vecs[11] = '{1'b1, 1'b0, 8'd0, 1'b0, '{1'b1, 1'b0, 2'd0, 1'b0}};

    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_in = 8'd0; bus.q_lead = 1'b0;

    // Reset state before any clock edge.
    #1;
    sb.push_back(ZERO);
    check_out("reset_state");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table: N=1 pattern, stop, load while stopped, restart at N=3.
    for (int v = 0; v < 12; v++) begin
      apply(vecs[v].en, vecs[v].ld, vecs[v].din, vecs[v].ql, vecs[v].e, $sformatf("table[%0d]", v));
    end

    // N=3, Q lagging: two full 12-cycle periods.
    apply(1'b0, 1'b0, 8'd0, 1'b0, ZERO, "n3_stop");
    for (int t = 0; t < 24; t++) begin
      apply(1'b1, 1'b0, 8'd0, 1'b0, wave(3, 1'b0, t), $sformatf("n3 t=%0d", t));
    end

    // N=2 with pending loads (last wins), then a load exactly on a boundary.
    apply(1'b0, 1'b1, 8'd2, 1'b0, ZERO, "n2_load_stopped");
    for (int t = 0; t < 36; t++) begin
      if (t < 8)       e = wave(2, 1'b0, t);
      else if (t < 28) e = wave(5, 1'b0, t - 8);
      else             e = wave(1, 1'b0, t - 28);
      if (t == 2)       apply(1'b1, 1'b1, 8'd9, 1'b0, e, $sformatf("pend t=%0d", t));
      else if (t == 3)  apply(1'b1, 1'b1, 8'd5, 1'b0, e, $sformatf("pend t=%0d", t));
      else if (t == 28) apply(1'b1, 1'b1, 8'd1, 1'b0, e, $sformatf("pend t=%0d", t));
      else              apply(1'b1, 1'b0, 8'd0, 1'b0, e, $sformatf("pend t=%0d", t));
    end

    // Stop with simultaneous load, then q_lead flipped mid-period.
    apply(1'b0, 1'b1, 8'd2, 1'b0, ZERO, "stop_and_load");
    for (int t = 0; t < 24; t++) begin
      ql = (t >= 3);
      e  = (t < 8) ? wave(2, 1'b0, t) : wave(2, 1'b1, t - 8);
      apply(1'b1, 1'b0, 8'd0, ql, e, $sformatf("qlead t=%0d", t));
    end

    // Drop en mid-phase 2, then restart from cnt=0.
    apply(1'b0, 1'b0, 8'd0, 1'b0, ZERO, "en_stop0");
    for (int t = 0; t < 5; t++) begin
      apply(1'b1, 1'b0, 8'd0, 1'b0, wave(2, 1'b0, t), $sformatf("run_a t=%0d", t));
    end
    apply(1'b0, 1'b0, 8'd0, 1'b0, ZERO, "en_drop_ph2");
    for (int t = 0; t < 11; t++) begin
      if (t == 9) apply(1'b1, 1'b1, 8'd7, 1'b0, wave(2, 1'b0, t), $sformatf("restart t=%0d", t));
      else        apply(1'b1, 1'b0, 8'd0, 1'b0, wave(2, 1'b0, t), $sformatf("restart t=%0d", t));
    end

    // Asynchronous reset with a pending ratio of 7 outstanding.
    #3;
    rst = 1'b0;
    #1;
    sb.push_back(ZERO);
    check_out("async_reset_immediate");
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back(ZERO);
    check_out("reset_held");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int t = 0; t < 12; t++) begin
      apply(1'b1, 1'b0, 8'd0, 1'b0, wave(1, 1'b0, t), $sformatf("post_reset t=%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
